au_log2_frac_seq: RTL

Sequential base-2 logarithm unit: computes floor(log2(a)) plus FRAC fractional bits of log2(a) for an unsigned WIDTH-bit input. It uses leading-one detection for the integer part and iterative mantissa squaring, one fractional bit per cycle. It extends the combinational integer-log2 function in the arithmetic-unit library with a fractional result, a zero-input flag and valid/ready handshakes on both sides. It targets datapaths where area matters more than throughput.

---
 rtl/au_log2_frac_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/au_log2_frac_seq.sv
// Sequential log2: floor(log2(a)) by leading-one detect, FRAC fraction bits by repeated mantissa squaring.
// Result FRAC+2 cycles after accept (2 for a==0); one op in flight, in_ready low until the result is taken.
module au_log2_frac_seq #(
   parameter  int WIDTH = 8,
   parameter  int FRAC  = 4,
   localparam int IW    = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IW-1:0]    z_int,
   output logic [FRAC-1:0]  z_frac,
   output logic             zero
);

   localparam int CW = ($clog2(FRAC) > 1) ? $clog2(FRAC) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_NORM,
      S_ITER,
      S_DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   m_q;
   logic [CW-1:0]      cnt;
   logic [IW-1:0]      lead_pos;
   logic [WIDTH-1:0]   m_norm;
   logic [2*WIDTH-1:0] sq;
   logic               frac_bit;
   logic [WIDTH-1:0]   m_sq;
   logic               unused_sq_lsb;

   // Highest set bit wins; mantissa is left-aligned so its MSB carries weight 1.0
   always_comb begin
      lead_pos = '0;
      m_norm   = a_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (a_q[i]) begin
            lead_pos = IW'(i);
            m_norm   = a_q << (WIDTH - 1 - i);
         end
      end
   end

   // m in [1,2) so m*m in [1,4): top bit set means the square reached 2, renormalise by one more shift
   always_comb begin
      sq       = (2*WIDTH)'(m_q) * (2*WIDTH)'(m_q);
      frac_bit = sq[2*WIDTH-1];
      m_sq     = frac_bit ? sq[2*WIDTH-1:WIDTH] : sq[2*WIDTH-2:WIDTH-1];
   end

   assign unused_sq_lsb = ^sq[WIDTH-2:0];

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = S_NORM;
         end
         S_NORM: begin
            if (a_q == '0) state_nxt = S_DONE;
            else           state_nxt = S_ITER;
         end
         S_ITER: begin
            if (cnt == CW'(FRAC - 1)) state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         a_q    <= '0;
         m_q    <= '0;
         cnt    <= '0;
         z_int  <= '0;
         z_frac <= '0;
         zero   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (in_valid) a_q <= a;
            end
            S_NORM: begin
               z_int  <= lead_pos;
               m_q    <= m_norm;
               cnt    <= '0;
               z_frac <= '0;
               zero   <= (a_q == '0);
            end
            S_ITER: begin
               m_q    <= m_sq;
               z_frac <= FRAC'({z_frac, frac_bit});
               cnt    <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
